// File: rtl/adc_spi_if.sv
// Parallel sample bus and SPI ADC pins for adc_spi_frontend.
// The master side is the front-end. The slave side is the board/reader side.
interface adc_spi_if;
  logic       sel;
  logic [8:0] adc;
  logic       adc_ch;
  logic       adc_valid;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;

  modport master (
    input  sel,
    input  spi_miso,
    output adc,
    output adc_ch,
    output adc_valid,
    output spi_cs_n,
    output spi_sclk,
    output spi_mosi
  );

  modport slave (
    output sel,
    output spi_miso,
    input  adc,
    input  adc_ch,
    input  adc_valid,
    input  spi_cs_n,
    input  spi_sclk,
    input  spi_mosi
  );
endinterface

// File: rtl/adc_spi_frontend.sv
// MCP3002-style SPI ADC front-end.
// The block runs back-to-back 16-bit frames on the channel chosen by `sel`.
// It publishes the upper 9 bits of each 10-bit conversion on a registered
// sample bus, with a one-cycle valid pulse.
module adc_spi_frontend #(
  parameter int CLK_DIV  = 25,
  parameter int CONV_GAP = 64
) (
  input  logic         clk,
  input  logic         rst,
  adc_spi_if.master    io
);

  localparam int DATA_W = 9;
  localparam int GW     = $clog2(CONV_GAP + 1);
  localparam int DW     = $clog2(CLK_DIV + 1);

  localparam logic [GW-1:0]     GAP_LAST  = GW'(CONV_GAP - 1);
  localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DATA_W-1:0] ADC_RESET = 9'd240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DW-1:0]     div_q, div_d;
  logic [3:0]        idx_q, idx_d;
  logic              hi_q, hi_d;
  logic              ch_q, ch_d;
  logic [9:0]        shift_q, shift_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] adc_q, adc_d;
  logic              adc_ch_q, adc_ch_d;
  logic              valid_q, valid_d;

  // Command word sent MSB-first: start, single-ended, channel, MSBF, then zeros.
  function automatic logic cmd_bit(input logic [3:0] idx, input logic ch);
    case (idx)
      4'd0:    cmd_bit = 1'b1;
      4'd1:    cmd_bit = 1'b1;
      4'd2:    cmd_bit = ch;
      4'd3:    cmd_bit = 1'b1;
      default: cmd_bit = 1'b0;
    endcase
  endfunction

  // Drop the conversion LSB to reduce the 10-bit result to the 9-bit sample bus.
  function automatic logic [DATA_W-1:0] trunc_sample(input logic [9:0] raw);
    trunc_sample = raw[9:1];
  endfunction

  // Next-state logic: gap timing, SCLK phase generation, MISO capture and result publish.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    div_d    = div_q;
    idx_d    = idx_q;
    hi_d     = hi_q;
    ch_d     = ch_q;
    shift_d  = shift_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    adc_d    = adc_q;
    adc_ch_d = adc_ch_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          // The channel is frozen here, so later `sel` changes wait for the next frame.
          state_d = SHIFT;
          ch_d    = io.sel;
          idx_d   = 4'd0;
          div_d   = '0;
          hi_d    = 1'b0;
          cs_n_d  = 1'b0;
          mosi_d  = cmd_bit(4'd0, io.sel);
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!hi_q) begin
            // SCLK rises on this edge. Sample MISO only for data bits D9..D0.
            hi_d   = 1'b1;
            sclk_d = 1'b1;
            if (idx_q >= 4'd5 && idx_q <= 4'd14) begin
              shift_d = {shift_q[8:0], io.spi_miso};
            end
          end else if (idx_q == 4'd15) begin
            // The last SCLK fall and the CS rise happen together on entry to DONE.
            state_d  = DONE;
            hi_d     = 1'b0;
            sclk_d   = 1'b0;
            cs_n_d   = 1'b1;
            mosi_d   = 1'b0;
            adc_d    = trunc_sample(shift_q);
            adc_ch_d = ch_q;
            valid_d  = 1'b1;
          end else begin
            // SCLK falls, and the next command bit is presented for the new low phase.
            hi_d   = 1'b0;
            sclk_d = 1'b0;
            idx_d  = idx_q + 4'd1;
            mosi_d = cmd_bit(idx_q + 4'd1, ch_q);
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        gap_d   = '0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // State and output registers. Reset aborts any frame and restores the idle bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      div_q    <= '0;
      idx_q    <= 4'd0;
      hi_q     <= 1'b0;
      ch_q     <= 1'b0;
      shift_q  <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      adc_q    <= ADC_RESET;
      adc_ch_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      hi_q     <= hi_d;
      ch_q     <= ch_d;
      shift_q  <= shift_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      adc_q    <= adc_d;
      adc_ch_q <= adc_ch_d;
      valid_q  <= valid_d;
    end
  end

  assign io.spi_cs_n  = cs_n_q;
  assign io.spi_sclk  = sclk_q;
  assign io.spi_mosi  = mosi_q;
  assign io.adc       = adc_q;
  assign io.adc_ch    = adc_ch_q;
  assign io.adc_valid = valid_q;

endmodule

// File: tb/tb_adc_spi_frontend.sv
// Testbench for adc_spi_frontend with a behavioural serial ADC model.
module tb_adc_spi_frontend;

  localparam int CLK_DIV  = 2;
  localparam int CONV_GAP = 4;
  localparam int PERIOD   = CONV_GAP + 32 * CLK_DIV + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  adc_spi_if io();

  adc_spi_frontend #(.CLK_DIV(CLK_DIV), .CONV_GAP(CONV_GAP)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  // ADC model. It latches the programmed value at CS fall, records MOSI on SCLK
  // rises, and shifts out D9..D0 on SCLK falls (null bit first).
  logic [9:0]  adc_val   = 10'd0;
  logic [9:0]  frame_val = 10'd0;
  logic [15:0] mosi_bits = 16'd0;
  int          rise_cnt  = 0;
  logic        miso_r    = 1'b0;

  assign io.spi_miso = miso_r;

  always @(negedge io.spi_cs_n or posedge io.spi_sclk) begin
    if (io.spi_sclk === 1'b1 && io.spi_cs_n === 1'b0) begin
      if (rise_cnt < 16) mosi_bits[rise_cnt] = io.spi_mosi;
      rise_cnt = rise_cnt + 1;
    end else if (io.spi_sclk === 1'b0) begin
      rise_cnt  = 0;
      mosi_bits = 16'd0;
      frame_val = adc_val;
    end
  end

  always @(negedge io.spi_sclk or negedge io.spi_cs_n) begin
    if (rise_cnt >= 5 && rise_cnt <= 14) miso_r = frame_val[14 - rise_cnt];
    else                                 miso_r = 1'b0;
  end

  // The expected command word: start, single-ended, channel, MSB-first, then zeros.
  function automatic logic [15:0] exp_cmd(input logic ch);
    logic [15:0] w;
    w = 16'h000B;
    w[2] = ch;
    return w;
  endfunction

  task automatic wait_valid(input int bound, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (io.adc_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_rises(input int n, input int bound, output bit ok);
    int cyc;
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (io.spi_cs_n === 1'b0 && rise_cnt >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    int n;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (io.spi_cs_n !== 1'b1) begin n_err++; $display("FAIL reset_cs_n got %b want 1", io.spi_cs_n); end
    n_cmp++; if (io.spi_sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk got %b want 0", io.spi_sclk); end
    n_cmp++; if (io.spi_mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi got %b want 0", io.spi_mosi); end
    n_cmp++; if (io.adc !== 9'd240) begin n_err++; $display("FAIL reset_adc got %0d want 240", io.adc); end
    n_cmp++; if (io.adc_ch !== 1'b0) begin n_err++; $display("FAIL reset_adc_ch got %b want 0", io.adc_ch); end
    n_cmp++; if (io.adc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", io.adc_valid); end
    rst = 1'b1;
    n = 0;
    while (n < 20 && io.spi_cs_n !== 1'b0) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++; if (n != CONV_GAP) begin n_err++; $display("FAIL reset_first_cs got %0d cycles want %0d", n, CONV_GAP); end
  endtask

  task automatic test_ch0;
    bit ok;
    int c;
    logic [9:0] v;
    wait_valid(200, ok, c);
    v = 10'h2A5;
    io.sel = 1'b0;
    adc_val = v;
    wait_valid(200, ok, c);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ch0_valid got timeout want pulse"); end
    n_cmp++; if (io.adc !== 9'(v >> 1)) begin n_err++; $display("FAIL ch0_adc got %h want %h", io.adc, 9'(v >> 1)); end
    n_cmp++; if (io.adc_ch !== 1'b0) begin n_err++; $display("FAIL ch0_adc_ch got %b want 0", io.adc_ch); end
    n_cmp++; if (mosi_bits !== exp_cmd(1'b0)) begin n_err++; $display("FAIL ch0_mosi got %h want %h", mosi_bits, exp_cmd(1'b0)); end
    n_cmp++; if (io.spi_cs_n !== 1'b1) begin n_err++; $display("FAIL ch0_cs_in_done got %b want 1", io.spi_cs_n); end
    @(negedge clk);
    n_cmp++; if (io.adc_valid !== 1'b0) begin n_err++; $display("FAIL ch0_valid_width got %b want 0", io.adc_valid); end
    n_cmp++; if (io.adc !== 9'(v >> 1)) begin n_err++; $display("FAIL ch0_adc_hold got %h want %h", io.adc, 9'(v >> 1)); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int c;
    wait_valid(200, ok, c);
    io.sel = 1'b1;
    adc_val = 10'h3FF;
    wait_valid(200, ok, c);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_valid1 got timeout want pulse"); end
    n_cmp++; if (io.adc !== 9'h1FF) begin n_err++; $display("FAIL b2b_adc1 got %h want 1ff", io.adc); end
    n_cmp++; if (io.adc_ch !== 1'b1) begin n_err++; $display("FAIL b2b_ch1 got %b want 1", io.adc_ch); end
    n_cmp++; if (mosi_bits !== exp_cmd(1'b1)) begin n_err++; $display("FAIL b2b_mosi got %h want %h", mosi_bits, exp_cmd(1'b1)); end
    adc_val = 10'h000;
    wait_valid(200, ok, c);
    n_cmp++; if (c != PERIOD) begin n_err++; $display("FAIL b2b_period got %0d want %0d", c, PERIOD); end
    n_cmp++; if (io.adc !== 9'h000) begin n_err++; $display("FAIL b2b_adc2 got %h want 000", io.adc); end
    n_cmp++; if (io.adc_ch !== 1'b1) begin n_err++; $display("FAIL b2b_ch2 got %b want 1", io.adc_ch); end
  endtask

  task automatic test_sel_toggle;
    bit ok;
    int c;
    logic [9:0] v1, v2;
    wait_valid(200, ok, c);
    v1 = 10'($urandom);
    io.sel = 1'b0;
    adc_val = v1;
    wait_rises(8, 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL tog_reach_idx7 got timeout want frame"); end
    io.sel = 1'b1;
    wait_valid(200, ok, c);
    n_cmp++; if (io.adc_ch !== 1'b0) begin n_err++; $display("FAIL tog_ch_cur got %b want 0", io.adc_ch); end
    n_cmp++; if (mosi_bits[2] !== 1'b0) begin n_err++; $display("FAIL tog_mosi2_cur got %b want 0", mosi_bits[2]); end
    n_cmp++; if (io.adc !== 9'(v1 >> 1)) begin n_err++; $display("FAIL tog_adc_cur got %h want %h", io.adc, 9'(v1 >> 1)); end
    v2 = 10'($urandom);
    adc_val = v2;
    wait_valid(200, ok, c);
    n_cmp++; if (io.adc_ch !== 1'b1) begin n_err++; $display("FAIL tog_ch_next got %b want 1", io.adc_ch); end
    n_cmp++; if (mosi_bits[2] !== 1'b1) begin n_err++; $display("FAIL tog_mosi2_next got %b want 1", mosi_bits[2]); end
    n_cmp++; if (io.adc !== 9'(v2 >> 1)) begin n_err++; $display("FAIL tog_adc_next got %h want %h", io.adc, 9'(v2 >> 1)); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int c;
    int pulses;
    logic [9:0] v;
    wait_valid(200, ok, c);
    v = 10'($urandom);
    io.sel = 1'b1;
    adc_val = v;
    wait_rises(11, 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_reach_idx10 got timeout want frame"); end
    rst = 1'b0;
    #1;
    n_cmp++; if (io.spi_cs_n !== 1'b1) begin n_err++; $display("FAIL rmid_cs_n got %b want 1", io.spi_cs_n); end
    n_cmp++; if (io.adc !== 9'd240) begin n_err++; $display("FAIL rmid_adc got %0d want 240", io.adc); end
    n_cmp++; if (io.spi_sclk !== 1'b0) begin n_err++; $display("FAIL rmid_sclk got %b want 0", io.spi_sclk); end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (io.adc_valid !== 1'b0) pulses++;
    end
    rst = 1'b1;
    for (int i = 0; i < CONV_GAP; i++) begin
      @(negedge clk);
      if (io.adc_valid !== 1'b0) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL rmid_no_valid got %0d pulses want 0", pulses); end
    wait_valid(200, ok, c);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_resume got timeout want pulse"); end
    n_cmp++; if (rise_cnt != 16) begin n_err++; $display("FAIL rmid_rises got %0d want 16", rise_cnt); end
    n_cmp++; if (io.adc !== 9'(v >> 1)) begin n_err++; $display("FAIL rmid_adc_after got %h want %h", io.adc, 9'(v >> 1)); end
  endtask

  task automatic test_protocol;
    bit ok;
    int c;
    int rises, viol, hi_run;
    logic p_cs, p_sclk, p_mosi;
    logic       exp_s;
    logic [9:0] exp_v;
    wait_valid(200, ok, c);
    exp_s = 1'($urandom);
    exp_v = 10'($urandom);
    io.sel = exp_s;
    adc_val = exp_v;
    hi_run = 1;
    rises = 0;
    viol = 0;
    p_cs = io.spi_cs_n;
    p_sclk = io.spi_sclk;
    p_mosi = io.spi_mosi;
    for (int f = 0; f < 10; f++) begin
      ok = 1'b0;
      c = 0;
      while (!ok && c < 200) begin
        @(negedge clk);
        c++;
        if (p_cs && !io.spi_cs_n) begin
          n_cmp++;
          if (hi_run < CONV_GAP + 1) begin n_err++; $display("FAIL prot_cs_gap frame %0d got %0d want >=%0d", f, hi_run, CONV_GAP + 1); end
          rises = 0;
        end
        if (io.spi_cs_n) hi_run = p_cs ? hi_run + 1 : 1;
        if (!io.spi_cs_n && !p_sclk && io.spi_sclk) rises++;
        if (p_sclk && io.spi_sclk && io.spi_mosi !== p_mosi) viol++;
        p_cs = io.spi_cs_n;
        p_sclk = io.spi_sclk;
        p_mosi = io.spi_mosi;
        if (io.adc_valid === 1'b1) ok = 1'b1;
      end
      n_cmp++; if (!ok) begin n_err++; $display("FAIL prot_valid frame %0d got timeout want pulse", f); end
      n_cmp++; if (rises != 16) begin n_err++; $display("FAIL prot_rises frame %0d got %0d want 16", f, rises); end
      n_cmp++; if (viol != 0) begin n_err++; $display("FAIL prot_mosi_stable frame %0d got %0d changes want 0", f, viol); end
      n_cmp++; if (io.adc !== 9'(exp_v >> 1)) begin n_err++; $display("FAIL prot_adc frame %0d got %h want %h", f, io.adc, 9'(exp_v >> 1)); end
      n_cmp++; if (io.adc_ch !== exp_s) begin n_err++; $display("FAIL prot_ch frame %0d got %b want %b", f, io.adc_ch, exp_s); end
      viol = 0;
      exp_s = 1'($urandom);
      exp_v = 10'($urandom);
      io.sel = exp_s;
      adc_val = exp_v;
    end
  endtask

  initial begin
    io.sel = 1'b0;
    test_reset();
    test_ch0();
    test_back_to_back();
    test_sel_toggle();
    test_reset_mid();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish before 500000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adc_spi_frontend.md
# adc_spi_frontend

Drives an external two-channel serial ADC (MCP3002-style SPI, 10-bit) and presents the 9-bit parallel sample bus consumed by the paddle ADC reader. It takes the reader's channel select, runs back-to-back conversions on the selected channel, and holds the latest result on `adc`. The block sits between the board's SPI ADC pins and the paddle position logic.

## Interface

- `CLK_DIV`, default 25: SCLK half-period in `clk` cycles (1 MHz SCLK at 50 MHz). Must be ≥ 2.
- `CONV_GAP`, default 64: idle `clk` cycles with `spi_cs_n` high before each frame. Must be ≥ 1.

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `sel`  in  1  channel select from the reader (0 = channel 0/player 1, 1 = channel 1/player 2)
- `adc`  out  9  latest sample, upper 9 bits of the 10-bit conversion
- `adc_ch`  out  1  channel that `adc` was converted from
- `adc_valid`  out  1  one-cycle pulse when `adc`/`adc_ch` update
- `spi_cs_n`  out  1  ADC chip select, active-low
- `spi_sclk`  out  1  SPI clock, idle low
- `spi_mosi`  out  1  command bits to the ADC
- `spi_miso`  in  1  conversion data from the ADC

## Operation

- FSM states: IDLE → SHIFT → DONE → IDLE.
- IDLE: `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0. A gap counter runs for CONV_GAP cycles. On the cycle it leaves IDLE, the block latches `sel` into `ch_ff` and clears the bit index.
- SHIFT: `spi_cs_n`=0. Sends 16 bit periods, index 0..15. Each period is a low phase (CLK_DIV cycles, `spi_sclk`=0) followed by a high phase (CLK_DIV cycles, `spi_sclk`=1).
  - MOSI per index: 0 → 1 (start), 1 → 1 (single-ended), 2 → `ch_ff`, 3 → 1 (MSB first), 4..15 → 0.
  - MOSI is updated at the start of each low phase.
  - Index 4 is the ADC null bit and is ignored. Indices 5..14 carry D9..D0 on MISO. Index 15 is don't-care.
  - MISO is captured into a 10-bit shift register on the `clk` edge where `spi_sclk` goes 0→1. Only indices 5..14 are shifted in.
- DONE (1 cycle): `spi_cs_n`=1, `spi_sclk`=0. Registered results are `adc` ← shift[9:1] (D9..D1), `adc_ch` ← `ch_ff`, and `adc_valid`=1. Then the block returns to IDLE and the gap counter reloads.
- `sel` changes during SHIFT or DONE have no effect on the frame in flight. They are picked up at the next IDLE→SHIFT transition.
- `adc` and `adc_ch` hold their values between frames. `adc_valid` is 0 in every state except DONE.
- Reset (`rst`=0, any state, takes effect immediately):
  - `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0
  - `adc`=9'd240, `adc_ch`=0, `adc_valid`=0
  - FSM returns to IDLE with the gap counter at 0 and the shift register cleared.
  - Any frame in progress is aborted.

## Timing

- All outputs are registered. There are no combinational paths from `sel` or `spi_miso` to any output.
- SHIFT lasts exactly 32·CLK_DIV cycles. Each frame has exactly 16 `spi_sclk` rising edges.
- `spi_cs_n` low to first SCLK rise is CLK_DIV cycles. Last SCLK fall to `spi_cs_n` rise is 0 cycles (both occur entering DONE).
- `spi_cs_n` is high for CONV_GAP+1 cycles between frames (DONE plus IDLE).
- Conversion period (between `adc_valid` pulses) is CONV_GAP + 32·CLK_DIV + 1 cycles.
- First frame after reset release: `spi_cs_n` falls CONV_GAP cycles after the first rising `clk` edge with `rst`=1.
- Latency from the frame's start-of-SHIFT to `adc` update is 32·CLK_DIV + 1 cycles.

## Test plan

All scenarios use CLK_DIV=2 and CONV_GAP=4, giving a 69-cycle conversion period. A behavioural ADC model shifts out a programmed 10-bit value on MISO, changing on SCLK falling edges.

- Reset: hold `rst`=0 → `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `adc`=240, `adc_ch`=0, `adc_valid`=0. Release `rst` → `spi_cs_n` falls after 4 cycles.
- `sel`=0, model returns 10'h2A5 → MOSI command 1,1,0,1. After DONE: `adc`=9'h152, `adc_ch`=0, `adc_valid` high for exactly 1 cycle.
- `sel`=1, model returns 10'h3FF, then 10'h000 on the next frame → MOSI bit 2 = 1. `adc`=9'h1FF then 9'h000, `adc_ch`=1. `adc_valid` pulses are 69 cycles apart.
- Toggle `sel` 0→1 at SHIFT index 7 → the current frame's MOSI bit 2 stays 0 and reports `adc_ch`=0. The next frame uses channel 1.
- Assert `rst` at SHIFT index 10 → in the same cycle `spi_cs_n`=1 and `adc`=240, with no `adc_valid` pulse. After release, a complete 16-edge frame follows.
- Protocol checker over 10 frames → exactly 16 SCLK rises per `spi_cs_n` low window. MOSI is stable while SCLK is high. `spi_cs_n` is high for ≥ 5 cycles between frames.
